// File: rtl/instr_mem.sv
// Loadable instruction memory for the 4-bit core.
// A valid/ready streaming port writes a program image word by word.
// A registered fetch port returns one word per cycle with 1-cycle latency.
// Locations at or above prog_count read as zero (NOP), so a partial or
// missing load never exposes stale storage contents to the fetch unit.
module instr_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic [ADDR_W:0]   prog_count,
    output logic              prog_err,
    output logic              loading,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Count value just before the final storage slot is written.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t            state;
    logic              xfer;
    logic [ADDR_W-1:0] wptr;

    // Storage has no reset; prog_count alone decides which words are valid.
    logic [DATA_W-1:0] mem [DEPTH];

    // The write pointer always equals the low bits of the word count, so it
    // is derived rather than kept as a second register that must track it.
    assign wptr       = prog_count[ADDR_W-1:0];
    assign prog_ready = (state == LOAD) && !prog_start;
    assign xfer       = prog_valid && prog_ready;
    assign loading    = (state == LOAD);

    // Load-control FSM: restart, word counting and overflow detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            prog_count <= '0;
            prog_err   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (prog_start) begin
                        state      <= LOAD;
                        prog_count <= '0;
                        prog_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (prog_start) begin
                        // Restart; any beat this cycle was refused via prog_ready.
                        prog_count <= '0;
                        prog_err   <= 1'b0;
                    end else if (xfer) begin
                        prog_count <= prog_count + 1'b1;
                        if (prog_last) begin
                            state <= RUN;
                        end else if (prog_count == LAST_CNT) begin
                            // Storage is full without a last marker: truncate.
                            state    <= RUN;
                            prog_err <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Program write port; only accepted beats reach the array.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wptr] <= prog_data;
        end
    end

    // Registered fetch; dropped while loading, unloaded words read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
        end else if (fetch_en && (state == RUN)) begin
            fetch_valid <= 1'b1;
            fetch_data  <= ({1'b0, fetch_addr} < prog_count) ? mem[fetch_addr] : '0;
        end else begin
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: a reference model of the loaded image
// produces expected fetch words, queued when a fetch is driven and compared
// when fetch_valid comes back.
module tb_instr_mem;

    logic       clk;
    logic       rst_n;
    logic       prog_start;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_last;
    logic       prog_ready;
    logic [4:0] prog_count;
    logic       prog_err;
    logic       loading;
    logic       fetch_en;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       fetch_valid;

    instr_mem #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_start (prog_start),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_last  (prog_last),
        .prog_ready (prog_ready),
        .prog_count (prog_count),
        .prog_err   (prog_err),
        .loading    (loading),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the loaded image.
    logic [7:0] mmem [16];
    int         mcount  = 0;
    bit         merr    = 0;
    bit         mload   = 0;
    logic [7:0] exp_last = 8'h00;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-22s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_word(input int a);
        return (a < mcount) ? mmem[a] : 8'h00;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".loading"},    32'(loading),    32'(mload));
        check({tag, ".prog_count"}, 32'(prog_count), 32'(mcount));
        check({tag, ".prog_err"},   32'(prog_err),   32'(merr));
    endtask

    // Drive one fetch request and queue its expected result.
    task automatic fetch(input int a);
        fetch_en   = 1'b1;
        fetch_addr = 4'(a);
        exp_q.push_back(model_word(a));
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic start_load();
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        mload  = 1;
        mcount = 0;
        merr   = 0;
    endtask

    task automatic beat(input logic [7:0] d, input bit last);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        #1;
        check("prog_ready_in_load", 32'(prog_ready), 32'd1);
        @(posedge clk);
        mmem[mcount] = d;
        mcount++;
        if (last) begin
            mload = 0;
        end else if (mcount == 16) begin
            mload = 0;
            merr  = 1;
        end
        #1;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        check_status("beat");
    endtask

    // Output monitor: compare returned words, otherwise data must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fetch_valid) begin
                check("fetch_valid_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_last = exp_q.pop_front();
                    check("fetch_data", 32'(fetch_data), 32'(exp_last));
                end
            end else begin
                check("fetch_data_held", 32'(fetch_data), 32'(exp_last));
            end
        end
    end

    logic [7:0] prog6 [6];

    initial begin
        prog6 = '{8'h46, 8'h4B, 8'h06, 8'h4D, 8'h43, 8'h13};
        rst_n      = 1'b0;
        prog_start = 1'b0;
        prog_valid = 1'b0;
        prog_data  = 8'h00;
        prog_last  = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = 4'h0;
        tick();
        tick();
        // Reset state
        check("rst.prog_ready",  32'(prog_ready),  32'd0);
        check("rst.fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst.fetch_data",  32'(fetch_data),  32'd0);
        check_status("rst");
        rst_n = 1'b1;
        tick();

        // Empty memory reads zero everywhere
        for (int a = 0; a < 16; a++) fetch(a);
        tick();

        // prog_valid in RUN is ignored
        prog_valid = 1'b1;
        prog_data  = 8'h77;
        #1;
        check("run.prog_ready", 32'(prog_ready), 32'd0);
        tick();
        prog_valid = 1'b0;
        check_status("run_ignore");

        // Six-word image with last on the final beat
        start_load();
        check_status("load6_start");
        for (int i = 0; i < 6; i++) beat(prog6[i], i == 5);
        for (int a = 0; a < 8; a++) fetch(a);
        tick();

        // Back-to-back fetches, then an idle cycle with data held
        fetch(5); fetch(0); fetch(5); fetch(15);
        tick();
        tick();

        // Fetch issued together with prog_start sees the pre-load image
        fetch_en   = 1'b1;
        fetch_addr = 4'd5;
        exp_q.push_back(model_word(5));
        start_load();
        fetch_en = 1'b0;
        for (int i = 0; i < 16; i++) beat(8'hA0 + 8'(i), 1'b0);
        fetch(15); fetch(0);
        tick();

        // New start clears the overflow flag
        start_load();
        check_status("err_clear");

        // Restart mid-load with a beat offered in the same cycle
        for (int i = 0; i < 3; i++) beat(8'hC0 + 8'(i), 1'b0);
        prog_start = 1'b1;
        prog_valid = 1'b1;
        prog_data  = 8'hEE;
        #1;
        check("restart.prog_ready", 32'(prog_ready), 32'd0);
        tick();
        prog_start = 1'b0;
        prog_valid = 1'b0;
        mcount = 0;
        check_status("restart");
        beat(8'h5A, 1'b0);
        beat(8'h3C, 1'b1);
        fetch(2); fetch(0); fetch(1);
        tick();

        // Fetch during LOAD is dropped, then reset mid-load
        start_load();
        for (int i = 0; i < 4; i++) beat(8'h90 + 8'(i), 1'b0);
        fetch_en   = 1'b1;
        fetch_addr = 4'd0;
        tick();
        fetch_en = 1'b0;
        check("load.fetch_dropped", 32'(fetch_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        mload = 0; mcount = 0; merr = 0;
        exp_last = 8'h00;
        check("midrst.prog_ready", 32'(prog_ready), 32'd0);
        check("midrst.fetch_data", 32'(fetch_data), 32'd0);
        check_status("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) fetch(a);
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
